// File: rtl/usb_enc_pkg.sv
// Shared types and constants for the USB packet serializer: PID codes and classes,
// FSM states, field lengths and CRC polynomials.
package usb_enc_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_e;

    typedef enum logic [1:0] {
        PCLS_TOKEN,
        PCLS_DATA,
        PCLS_SHORT
    } pid_class_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SYNC,
        ST_PID,
        ST_ADDR,
        ST_ENDP,
        ST_DATA,
        ST_CRC5,
        ST_CRC16
    } state_e;

    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

    localparam int unsigned SYNC_BITS  = 8;
    localparam int unsigned PID_BITS   = 8;
    localparam int unsigned ADDR_BITS  = 7;
    localparam int unsigned ENDP_BITS  = 4;
    localparam int unsigned CRC5_BITS  = 5;
    localparam int unsigned CRC16_BITS = 16;

    localparam logic [4:0]  CRC5_POLY  = 5'h05;
    localparam logic [4:0]  CRC5_INIT  = 5'h1F;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Anything that is neither a token nor a data PID is sent as PID only.
    function automatic pid_class_e pid_class(input logic [3:0] p);
        case (p)
            PID_OUT, PID_IN, PID_SETUP: pid_class = PCLS_TOKEN;
            PID_DATA0, PID_DATA1:       pid_class = PCLS_DATA;
            default:                    pid_class = PCLS_SHORT;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc_serial.sv
// Bit-serial CRC generator; crc presents the complemented register so it can be sent directly.
module usb_crc_serial #(
    parameter int unsigned     WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY = '0,
    parameter logic [WIDTH-1:0] INIT = '1
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic             din,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] crc
);

    logic [WIDTH-1:0] lfsr;
    logic             fb;

    assign fb  = lfsr[WIDTH-1] ^ din;
    assign crc = ~lfsr;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            lfsr <= '0;
        end else if (clr) begin
            lfsr <= INIT;
        end else if (en) begin
            lfsr <= {lfsr[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

endmodule

// File: rtl/usb_pkt_serializer.sv
// Serial USB packet encoder: SYNC, PID, token/data fields, LSB-first per field, with pause backpressure.
// Define USB_ENC_CRC_EN to append CRC5 to tokens and CRC16 to data packets.
module usb_pkt_serializer
    import usb_enc_pkg::*;
#(
    parameter int unsigned MAX_DATA_BYTES = 8,
    parameter int unsigned LEN_W          = $clog2(MAX_DATA_BYTES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_L,
    input  logic                        pktready,
    input  logic [3:0]                  pid,
    input  logic [6:0]                  addr,
    input  logic [3:0]                  endp,
    input  logic [8*MAX_DATA_BYTES-1:0] data,
    input  logic [LEN_W-1:0]            data_len,
    input  logic                        pause,
    output logic                        outb,
    output logic                        sending,
    output logic                        gotpkt,
    output logic                        done
);

    localparam int unsigned CNT_W = $clog2(8 * MAX_DATA_BYTES + 1);

    state_e                      state;
    state_e                      state_nx;
    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            field_last;
    logic                        field_end;
    logic                        accept;
    logic [7:0]                  sh;
    logic [8*MAX_DATA_BYTES-1:0] data_sr;
    logic [3:0]                  pid_q;
    logic [6:0]                  addr_q;
    logic [3:0]                  endp_q;
    logic [LEN_W-1:0]            len_q;
    logic [LEN_W-1:0]            len_clamp;
    pid_class_e                  cls;

    assign len_clamp = (data_len > LEN_W'(MAX_DATA_BYTES)) ? LEN_W'(MAX_DATA_BYTES) : data_len;
    assign cls       = pid_class(pid_q);
    assign sending   = (state != ST_IDLE) && (state != ST_LOAD);
    assign accept    = sending && !pause;
    assign gotpkt    = (state == ST_LOAD);
    assign field_end = (cnt == field_last);

    always_comb begin
        field_last = '0;
        case (state)
            ST_SYNC:  field_last = CNT_W'(SYNC_BITS - 1);
            ST_PID:   field_last = CNT_W'(PID_BITS - 1);
            ST_ADDR:  field_last = CNT_W'(ADDR_BITS - 1);
            ST_ENDP:  field_last = CNT_W'(ENDP_BITS - 1);
            ST_DATA:  field_last = CNT_W'({len_q, 3'b000}) - CNT_W'(1);
            ST_CRC5:  field_last = CNT_W'(CRC5_BITS - 1);
            ST_CRC16: field_last = CNT_W'(CRC16_BITS - 1);
            default:  field_last = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (pktready) state_nx = ST_LOAD;
            ST_LOAD: state_nx = ST_SYNC;
            default: begin
                if (accept && field_end) begin
                    case (state)
                        ST_SYNC: state_nx = ST_PID;
                        ST_PID: begin
                            case (cls)
                                PCLS_TOKEN: state_nx = ST_ADDR;
                                PCLS_DATA: begin
                                    if (len_q != '0)
                                        state_nx = ST_DATA;
                                    else
`ifdef USB_ENC_CRC_EN
                                        state_nx = ST_CRC16;
`else
                                        state_nx = ST_IDLE;
`endif
                                end
                                default: state_nx = ST_IDLE;
                            endcase
                        end
                        ST_ADDR: state_nx = ST_ENDP;
`ifdef USB_ENC_CRC_EN
                        ST_ENDP: state_nx = ST_CRC5;
                        ST_DATA: state_nx = ST_CRC16;
`else
                        ST_ENDP: state_nx = ST_IDLE;
                        ST_DATA: state_nx = ST_IDLE;
`endif
                        default: state_nx = ST_IDLE;
                    endcase
                end
            end
        endcase
        done = accept && field_end && (state_nx == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sh      <= '0;
            data_sr <= '0;
            pid_q   <= '0;
            addr_q  <= '0;
            endp_q  <= '0;
            len_q   <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_LOAD) begin
                pid_q   <= pid;
                addr_q  <= addr;
                endp_q  <= endp;
                data_sr <= data;
                len_q   <= len_clamp;
                sh      <= SYNC_PATTERN;
                cnt     <= '0;
            end else if (accept) begin
                if (state == ST_DATA)
                    data_sr <= data_sr >> 1;
                // The header shifter is reloaded with the next field as the current one ends.
                if (field_end) begin
                    cnt <= '0;
                    case (state_nx)
                        ST_PID:  sh <= {~pid_q, pid_q};
                        ST_ADDR: sh <= {1'b0, addr_q};
                        ST_ENDP: sh <= {4'b0000, endp_q};
                        default: sh <= '0;
                    endcase
                end else begin
                    cnt <= cnt + CNT_W'(1);
                    sh  <= sh >> 1;
                end
            end
        end
    end

`ifdef USB_ENC_CRC_EN
    logic [CRC5_BITS-1:0]  crc5;
    logic [CRC16_BITS-1:0] crc16;
    logic [2:0]            crc5_idx;
    logic [3:0]            crc16_idx;

    assign crc5_idx  = 3'(CRC5_BITS - 1) - cnt[2:0];
    assign crc16_idx = 4'(CRC16_BITS - 1) - cnt[3:0];

    usb_crc_serial #(
        .WIDTH (CRC5_BITS),
        .POLY  (CRC5_POLY),
        .INIT  (CRC5_INIT)
    ) u_crc5 (
        .clk   (clk),
        .rst_L (rst_L),
        .din   (outb),
        .en    (accept && ((state == ST_ADDR) || (state == ST_ENDP))),
        .clr   (state == ST_LOAD),
        .crc   (crc5)
    );

    usb_crc_serial #(
        .WIDTH (CRC16_BITS),
        .POLY  (CRC16_POLY),
        .INIT  (CRC16_INIT)
    ) u_crc16 (
        .clk   (clk),
        .rst_L (rst_L),
        .din   (outb),
        .en    (accept && (state == ST_DATA)),
        .clr   (state == ST_LOAD),
        .crc   (crc16)
    );
`endif

    // CRC fields are read MSB first straight from the held LFSR rather than via the shifter.
    always_comb begin
        outb = 1'b0;
        case (state)
            ST_SYNC, ST_PID, ST_ADDR, ST_ENDP: outb = sh[0];
            ST_DATA:  outb = data_sr[0];
`ifdef USB_ENC_CRC_EN
            ST_CRC5:  outb = crc5[crc5_idx];
            ST_CRC16: outb = crc16[crc16_idx];
`endif
            default:  outb = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_usb_pkt_serializer.sv
// Scoreboard bench for usb_pkt_serializer: expected bit streams are queued at stimulus time
// and a negedge monitor compares every presented bit; honours USB_ENC_CRC_EN like the design.
module tb_usb_pkt_serializer;

    localparam int unsigned MAXB = 8;
    localparam int unsigned LW   = $clog2(MAXB + 1);

    logic              clk      = 1'b0;
    logic              rst_L    = 1'b0;
    logic              pktready = 1'b0;
    logic              pause    = 1'b0;
    logic [3:0]        pid      = '0;
    logic [6:0]        addr     = '0;
    logic [3:0]        endp     = '0;
    logic [8*MAXB-1:0] data     = '0;
    logic [LW-1:0]     data_len = '0;
    logic              outb;
    logic              sending;
    logic              gotpkt;
    logic              done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit b;
        bit last;
    } exp_t;

    exp_t sb[$];
    bit   exp_bits[$];

    int pause_mode = 0;
    int rel        = 0;
    int fin        = 0;

    usb_pkt_serializer #(.MAX_DATA_BYTES(MAXB)) dut (
        .clk      (clk),
        .rst_L    (rst_L),
        .pktready (pktready),
        .pid      (pid),
        .addr     (addr),
        .endp     (endp),
        .data     (data),
        .data_len (data_len),
        .pause    (pause),
        .outb     (outb),
        .sending  (sending),
        .gotpkt   (gotpkt),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void push_lsb(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) exp_bits.push_back(v[i]);
    endfunction

    function automatic void push_msb(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_bits.push_back(v[i]);
    endfunction

    // Textbook CRC: divide the message by the generator starting from the init residue.
    function automatic logic [15:0] crc_of(input bit msg[$], input int w,
                                           input logic [15:0] poly, input logic [15:0] init);
        logic [15:0] r;
        logic [15:0] mask;
        bit          top;
        mask = 16'((32'd1 << w) - 1);
        r    = init;
        foreach (msg[i]) begin
            top = r[w-1] ^ msg[i];
            r   = (r << 1) & mask;
            if (top) r = r ^ poly;
        end
        return ~r & mask;
    endfunction

    function automatic void model(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                                  input logic [8*MAXB-1:0] d, input int len);
        bit body[$];
        int n;
        exp_bits.delete();
        push_lsb(16'h0080, 8);
        push_lsb({8'h00, ~p, p}, 8);
        if (p == 4'b0001 || p == 4'b1001 || p == 4'b1101) begin
            push_lsb(16'(a), 7);
            push_lsb(16'(e), 4);
            for (int i = 0; i < 7; i++) body.push_back(a[i]);
            for (int i = 0; i < 4; i++) body.push_back(e[i]);
`ifdef USB_ENC_CRC_EN
            push_msb(crc_of(body, 5, 16'h0005, 16'h001F), 5);
`endif
        end else if (p == 4'b0011 || p == 4'b1011) begin
            n = (len > int'(MAXB)) ? int'(MAXB) : len;
            for (int i = 0; i < 8 * n; i++) begin
                exp_bits.push_back(d[i]);
                body.push_back(d[i]);
            end
`ifdef USB_ENC_CRC_EN
            push_msb(crc_of(body, 16, 16'h8005, 16'hFFFF), 16);
`endif
        end
    endfunction

    task automatic load_sb();
        int nb;
        nb = exp_bits.size();
        foreach (exp_bits[i]) sb.push_back('{exp_bits[i], (i == nb - 1)});
    endtask

    task automatic send_pkt(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                            input logic [8*MAXB-1:0] d, input int len, input bit hold, input bit cont);
        int nb;
        int cyc;
        int np;
        bit got;
        nb = exp_bits.size();
        load_sb();
        if (!cont) begin
            @(posedge clk); #1;
            pid = p; addr = a; endp = e; data = d; data_len = LW'(len);
            pktready = 1'b1;
        end
        @(posedge clk); #1;
        chk("gotpkt_in_load", 32'(gotpkt), 32'd1);
        chk("sending_in_load", 32'(sending), 32'd0);
        if (!hold) pktready = 1'b0;
        @(negedge clk);
        cyc = 0; np = 0; got = 1'b0;
        while (!got && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
            else if (pause) np++;
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("pkt_cycles", 32'(cyc), 32'(nb + np));
        @(posedge clk); #1;
        chk("sending_after_done", 32'(sending), 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_L) begin
            if (sending) begin
                chk("gotpkt_while_sending", 32'(gotpkt), 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: got outb=%0b with sending=1, expected no packet bit (t=%0t)",
                             outb, $time);
                end else begin
                    chk("outb", 32'(outb), 32'(sb[0].b));
                    chk("done_flag", 32'(done), 32'(sb[0].last && !pause));
                    if (!pause) void'(sb.pop_front());
                end
            end else begin
                chk("idle_outb", 32'(outb), 32'd0);
                chk("idle_done", 32'(done), 32'd0);
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (gotpkt) rel = 0;
        else rel++;
        case (pause_mode)
            1:       pause = ($urandom_range(0, 4) == 0);
            2:       pause = (rel >= 20 && rel <= 22) || rel == fin || rel == fin + 1;
            default: pause = 1'b0;
        endcase
    end

    initial begin
        logic [8*MAXB-1:0] d;
        logic [3:0]        p;
        logic [6:0]        a;
        logic [3:0]        e;
        int                len;

        #1;
        chk("reset_outb", 32'(outb), 32'd0);
        chk("reset_sending", 32'(sending), 32'd0);
        chk("reset_gotpkt", 32'(gotpkt), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        #21 rst_L = 1'b1;

        // ACK: SYNC then 0,1,0,0,1,0,1,1
        exp_bits.delete();
        push_lsb(16'h0080, 8);
        push_lsb(16'h00D2, 8);
        send_pkt(4'b0010, 7'h00, 4'h0, '0, 0, 1'b0, 1'b0);

        // OUT addr 15 endp E
        exp_bits.delete();
        push_lsb(16'h0080, 8);
        push_lsb(16'h00E1, 8);
        push_lsb(16'h0015, 7);
        push_lsb(16'h000E, 4);
`ifdef USB_ENC_CRC_EN
        push_msb(16'h0017, 5);
`endif
        send_pkt(4'b0001, 7'h15, 4'hE, '0, 0, 1'b0, 1'b0);

        // DATA0 with bytes 00 01 02 03
        exp_bits.delete();
        push_lsb(16'h0080, 8);
        push_lsb(16'h00C3, 8);
        push_lsb(16'h0000, 8);
        push_lsb(16'h0001, 8);
        push_lsb(16'h0002, 8);
        push_lsb(16'h0003, 8);
`ifdef USB_ENC_CRC_EN
        push_msb(16'hF75E, 16);
`endif
        send_pkt(4'b0011, 7'h00, 4'h0, 64'h0000_0000_0302_0100, 4, 1'b0, 1'b0);

        // DATA0, zero length
        exp_bits.delete();
        push_lsb(16'h0080, 8);
        push_lsb(16'h00C3, 8);
`ifdef USB_ENC_CRC_EN
        push_msb(16'h0000, 16);
`endif
        send_pkt(4'b0011, 7'h00, 4'h0, '0, 0, 1'b0, 1'b0);

        // pause three cycles mid-ADDR and two cycles on the final bit
        model(4'b1001, 7'h2A, 4'h5, '0, 0);
        fin = exp_bits.size() + 3;
        pause_mode = 2;
        send_pkt(4'b1001, 7'h2A, 4'h5, '0, 0, 1'b0, 1'b0);
        pause_mode = 0;

        // over-long length clamps; pktready held gives back-to-back packets with one idle cycle
        for (int i = 0; i < int'(MAXB); i++) d[i*8 +: 8] = 8'($urandom);
        model(4'b1011, 7'h00, 4'h0, d, 15);
        send_pkt(4'b1011, 7'h00, 4'h0, d, 15, 1'b1, 1'b0);
        model(4'b1011, 7'h00, 4'h0, d, 15);
        send_pkt(4'b1011, 7'h00, 4'h0, d, 15, 1'b0, 1'b1);

        // reset in the middle of the payload, then a fresh packet
        for (int i = 0; i < int'(MAXB); i++) d[i*8 +: 8] = 8'($urandom);
        model(4'b1011, 7'h00, 4'h0, d, 8);
        load_sb();
        @(posedge clk); #1;
        pid = 4'b1011; data = d; data_len = LW'(8); pktready = 1'b1;
        @(posedge clk); #1;
        pktready = 1'b0;
        repeat (30) @(posedge clk);
        #3 rst_L = 1'b0;
        #1;
        chk("midreset_outb", 32'(outb), 32'd0);
        chk("midreset_sending", 32'(sending), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        sb.delete();
        #10 rst_L = 1'b1;
        model(4'b1011, 7'h00, 4'h0, d, 8);
        send_pkt(4'b1011, 7'h00, 4'h0, d, 8, 1'b0, 1'b0);

        // random packets with random backpressure
        pause_mode = 1;
        repeat (40) begin
            p   = 4'($urandom_range(0, 15));
            a   = 7'($urandom);
            e   = 4'($urandom);
            len = int'($urandom_range(0, 15));
            for (int i = 0; i < int'(MAXB); i++) d[i*8 +: 8] = 8'($urandom);
            model(p, a, e, d, len);
            send_pkt(p, a, e, d, len, 1'b0, 1'b0);
        end
        pause_mode = 0;

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_pkt_serializer.md
# usb_pkt_serializer

Parametrised serial packet encoder for the USB host-side transmit path, sitting between the packet-assembly logic and the NRZI/bit-stuffing stage. It accepts a parallel packet description (PID, address, endpoint, variable-length data payload) and emits it one bit per clock, LSB-first per field, with a leading SYNC field. When CRC is compiled in, it appends CRC5 (tokens) or CRC16 (data). It honours a `pause` backpressure input from the bit-stuffer.

## Interface
- `MAX_DATA_BYTES`, 8: maximum data payload in bytes (1..64)
- `LEN_W`, $clog2(MAX_DATA_BYTES+1): width of `data_len`
- `clk`  in  1  clock
- `rst_L`  in  1  reset, asynchronous, active-low
- `pktready`  in  1  packet fields valid; sampled only in IDLE
- `pid`  in  4  packet identifier
- `addr`  in  7  device address (tokens)
- `endp`  in  4  endpoint (tokens)
- `data`  in  8*MAX_DATA_BYTES  payload; byte 0 in bits [7:0], sent first
- `data_len`  in  LEN_W  payload byte count; values > MAX_DATA_BYTES clamp to MAX_DATA_BYTES
- `pause`  in  1  hold current bit, do not advance
- `outb`  out  1  serial bit
- `sending`  out  1  high while `outb` carries a packet bit
- `gotpkt`  out  1  one-cycle pulse: fields captured
- `done`  out  1  one-cycle pulse: final bit of packet accepted

## Operation
- PID classes: token OUT 0001, IN 1001, SETUP 1101; data DATA0 0011, DATA1 1011; all other codes are PID-only (ACK 0010, NAK 1010, STALL 1110, reserved).
- States: IDLE, LOAD, SYNC, PID, ADDR, ENDP, DATA, CRC5, CRC16.
- IDLE -> LOAD on `pktready`. LOAD: capture all fields and the clamped length, pulse `gotpkt`, clear the bit counter, go to SYNC.
- SYNC: 8 bits, value 8'b1000_0000 as sent (seven 0s then 1). PID: 8 bits `{~pid,pid}`, `pid[0]` first.
- After PID: token -> ADDR (7) -> ENDP (4) -> CRC5 (5) -> IDLE; data -> DATA (8*len bits; skipped when len=0) -> CRC16 (16) -> IDLE; PID-only -> IDLE.
- CRC5: poly x^5+x^2+1, init 5'h1F, over ADDR+ENDP bits in send order; send the complement, MSB first. CRC16: poly 0x8005, init 16'hFFFF, over DATA bits; send the complement, MSB first.
- Bit advance: a bit is accepted on a clock edge where the state is SYNC..CRC16 and `pause`=0. The shift register, CRC LFSR and counter advance only then. With `pause`=1, `outb`, state and counter hold.
- `done` is high in the cycle carrying the final bit with `pause`=0. The next state is IDLE.
- `pktready` is ignored outside IDLE. There is no back-to-back without IDLE: minimum one IDLE cycle between packets.
- Outputs in IDLE/LOAD: `outb`=0, `sending`=0.

## Timing
- Reset (async): state IDLE, all counters/shift regs/LFSRs cleared; `outb`=0, `sending`=0, `gotpkt`=0, `done`=0. A reset mid-packet abandons the packet immediately, with no partial `done`.
- `pktready` high at edge N: LOAD during cycle N..N+1 (`gotpkt`=1), first SYNC bit on `outb` in cycle N+1..N+2.
- Bits per packet without pauses: token 32, data 32+8*len, PID-only 16. Each pause cycle adds exactly one cycle.
- Counter width is sufficient for 8*MAX_DATA_BYTES and must not wrap.

## Configuration
- `USB_ENC_CRC_EN` defined: CRC5/CRC16 states and LFSRs are present, as above.
- Undefined: CRC states and LFSRs are removed. The token ends after ENDP (27 bits). A data packet ends after DATA. A zero-length data packet ends after PID (16 bits).

## Structure
- Package `usb_enc_pkg`: PID enum, PID-class decode function, SYNC constant, field-length localparams, CRC polynomials and init values.
- Sub-module `usb_crc_serial` (params WIDTH, POLY, INIT; inputs bit, en, clr; output complemented CRC), instantiated for CRC5 and CRC16.

## Test plan
- Reset mid-DATA -> `outb`/`sending` go to 0 asynchronously. The next `pktready` sends a full fresh packet.
- ACK (0010) -> 16 bits, SYNC then 0,1,0,0,1,0,1,1. `gotpkt` one cycle, `done` on bit 16, `sending` drops the next cycle.
- OUT, addr=7'h15, endp=4'hE, CRC on -> 32 bits. CRC5 field sent = 5'b10111 MSB first; `done` on bit 32.
- DATA0, len=4, bytes 00 01 02 03, CRC on -> 64 bits. CRC16 field = 16'hF75E MSB first. Also len=0 -> CRC16 field 16'h0000 after PID.
- `pause` asserted for 3 cycles mid-ADDR and on the final CRC bit -> `outb` holds, total length +3+N, `done` only once `pause` drops.
- `data_len`=15 with MAX_DATA_BYTES=8 -> exactly 64 data bits sent. `pktready` held high throughout -> packets repeat with one IDLE cycle between them.
